rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
// PURPOSE
//   8-way round-robin arbiter that shares one resource between 8 requesters.
//   Issues a registered one-hot grant plus its 3-bit binary index, so consumers can use either form.
//   Grant is held while the owner keeps req asserted, bounded by a hold limit for fairness.
//   Sits in front of any shared datapath, e.g. a bus or a decoded-select output.
// PARAMETERS
//   MAX_HOLD  16  max consecutive grant cycles per owner while others wait; 0 = unlimited hold
//   HCNT_W    5   hold counter width; must satisfy 2**HCNT_W > MAX_HOLD
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   en         in   1  1 = arbitration enabled; 0 = no new grants (current grant still ends normally)
//   req        in   8  request vector, bit i = requester i, level-sensitive
//   gnt        out  8  one-hot grant, registered; all-zero when idle
//   gnt_idx    out  3  binary index of granted requester; holds last value when idle
//   gnt_valid  out  1  1 while gnt != 0
// BEHAVIOUR
//   Reset (async assert, sync deassert by caller): gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE,
//     last_ptr=7 (first search starts at 0), hold_cnt=0.
//   FSM states:
//     IDLE: if en & |req -> GRANT to first set req bit searching last_ptr+1 .. last_ptr (wrapping mod 8).
//     GRANT: owner o = gnt_idx. Evaluate each cycle:
//       a) req[o]==0 (release): pick next from req & ~(1<<o).
//          Found & en -> load new grant same edge (zero-bubble handoff). Else -> IDLE, gnt=0.
//       b) req[o]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, other reqs pending & en:
//          rotate to next (forced) same edge.
//       c) otherwise keep grant; hold_cnt++ (saturates at MAX_HOLD-1 when no one else waits).
//   Latency: req rise in cycle n -> gnt in cycle n+1 (registered). No combinational req->gnt path.
//   Every grant load: last_ptr<=new idx, hold_cnt<=0, gnt<=1<<idx, gnt_idx<=idx, gnt_valid<=1.
//   Owner is never regranted on its own forced rotation if others wait; it rejoins at lowest priority.
//   Search priority: strictly rotating from last_ptr+1. Index 7 wraps to 0.
//   en=0 in IDLE: stay IDLE regardless of req. en=0 in GRANT: rule c) only; a) -> IDLE.
//   Simultaneous release + new reqs: handled by a); releasing bit is excluded even if its req glitches back.
//   Requests are not latched; a req dropped before being granted is lost (no pulse capture).
//   Invariant: gnt is always zero or one-hot; gnt_valid == |gnt; gnt == (1<<gnt_idx) when valid.
//   Reset mid-grant: outputs clear immediately (async), pointer returns to 7.
// STRUCTURE
//   Shared pkg arb_pkg: localparam NREQ=8, IDX_W=3; state enum {IDLE, GRANT}.
//   Sub-module rr_pick8 (combinational): inputs req[7:0], start[2:0]; outputs found, idx[2:0].
//     Returns the first set bit at or after start, wrapping mod 8.
//     Implement as rotate, priority-encode, add start mod 8.
//   Top: FSM + hold counter + output regs. One-hot gnt is produced by decoding the next idx before the register.
// TESTING
//   1 Reset: drive req=8'hFF during rst_n=0 -> gnt=0, gnt_idx=0, gnt_valid=0; first grant after release = 8'h01.
//   2 Single: req=8'h08 at cycle n -> gnt=8'h08, gnt_idx=3 at n+1; hold 40 cycles, MAX_HOLD=16
//       -> grant kept (no contender).
//   3 Fair rotation: MAX_HOLD=4, req=8'hFF held -> gnt sequence 01,02,04,...,80,01, each exactly 4 cycles.
//   4 Handoff: gnt=8'h01 with req=8'h05; drop req[0] -> gnt=8'h04 on next edge, gnt_valid stays 1 (no bubble).
//   5 Wrap/priority: last grant idx 6, then req=8'h81 -> gnt=8'h80; release -> gnt=8'h01.
//   6 en/reset: en=0 with req=8'h10 -> gnt stays 0;
//       mid-grant rst_n pulse -> gnt=0 async, next grant searches from 0.
//   Assertions on all runs: $onehot0(gnt), gnt_valid==|gnt, no req-to-gnt in same cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: widths, FSM states and
// a one-hot decode helper used when loading a grant.
package arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority picker: returns the first set request bit at or
// after 'start', wrapping modulo 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDX_W-1:0]  rot_idx;

  // Rotate right by 'start' so the search origin lands on bit 0.
  always_comb begin
    req_dbl = {req, req} >> start;
    req_rot = req_dbl[NREQ-1:0];
  end

  always_comb begin
    rot_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rot_idx = IDX_W'(i);
      end
    end
  end

  assign found = |req;
  // Three-bit add wraps naturally modulo 8.
  assign idx   = rot_idx + start;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot and binary grant outputs and a
// per-owner hold limit that forces rotation when other requesters are waiting.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HCNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam bit HoldLimited = (MAX_HOLD != 0);
  localparam logic [HCNT_W-1:0] HoldLast = HoldLimited ? HCNT_W'(MAX_HOLD - 1) : '0;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_ptr_q, last_ptr_d;
  logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;

  logic [NREQ-1:0]   pick_req;
  logic [IDX_W-1:0]  pick_start;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              hold_at_limit;
  logic              load;

  // gnt_q is zero when idle, so masking it out serves both states and keeps the
  // current owner from being re-picked on release or forced rotation.
  assign pick_req   = req & ~gnt_q;
  assign pick_start = last_ptr_q + 1'b1;

  rr_pick8 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign hold_at_limit = HoldLimited && (hold_cnt_q == HoldLast);

  always_comb begin
    state_d     = state_q;
    last_ptr_d  = last_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && pick_found) begin
          load = 1'b1;
        end
      end
      StGrant: begin
        if (!req[gnt_idx_q]) begin
          if (en && pick_found) begin
            load = 1'b1;
          end else begin
            state_d     = StIdle;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
          end
        end else if (hold_at_limit && en && pick_found) begin
          load = 1'b1;
        end else if (HoldLimited && !hold_at_limit) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase

    if (load) begin
      state_d     = StGrant;
      last_ptr_d  = pick_idx;
      hold_cnt_d  = '0;
      gnt_d       = idx2onehot(pick_idx);
      gnt_idx_d   = pick_idx;
      gnt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_ptr_q  <= IDX_W'(NREQ - 1);
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ptr_q  <= last_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (hold limit 16 and 4) share stimulus and are
// compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  logic [7:0] gnt16, gnt4;
  logic [2:0] idx16, idx4;
  logic       v16, v4;

  logic [7:0] snap16 = 8'h00;
  logic [7:0] snap4  = 8'h00;
  logic       inv_on = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16), .HCNT_W(5)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt16),
    .gnt_idx   (idx16),
    .gnt_valid (v16)
  );

  rr_arbiter8 #(.MAX_HOLD(4), .HCNT_W(3)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt4),
    .gnt_idx   (idx4),
    .gnt_valid (v4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model state per instance: owner (-1 = idle), search origin, last index, cycles held.
  int m_maxh  [2] = '{16, 4};
  int m_owner [2];
  int m_last  [2];
  int m_idx   [2];
  int m_held  [2];

  function automatic int search(input logic [7:0] r, input int excl, input int start);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (start + k) % 8;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = 7;
      m_idx[d]   = 0;
      m_held[d]  = 0;
    end
  endtask

  task automatic model_grant(input int d, input int o);
    m_owner[d] = o;
    m_last[d]  = o;
    m_idx[d]   = o;
    m_held[d]  = 1;
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int nxt;
      nxt = search(req, m_owner[d], (m_last[d] + 1) % 8);
      if (m_owner[d] < 0) begin
        if (en && nxt >= 0) model_grant(d, nxt);
      end else if (!req[m_owner[d]]) begin
        if (en && nxt >= 0) model_grant(d, nxt);
        else m_owner[d] = -1;
      end else if (m_maxh[d] != 0 && m_held[d] >= m_maxh[d] && en && nxt >= 0) begin
        model_grant(d, nxt);
      end else begin
        m_held[d]++;
      end
    end
  endtask

  function automatic logic [31:0] exp_word(input int d);
    logic [7:0] g;
    g = 8'h00;
    if (m_owner[d] >= 0) g = 8'h01 << m_owner[d];
    return {20'd0, (m_owner[d] >= 0), 3'(m_idx[d]), g};
  endfunction

  task automatic compare_all();
    check_eq("model16", {20'd0, v16, idx16, gnt16}, exp_word(0));
    check_eq("model4",  {20'd0, v4,  idx4,  gnt4},  exp_word(1));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
    snap16 = gnt16;
    snap4  = gnt4;
  endtask

  // Called just after step(); pulses reset between clock edges.
  task automatic apply_reset();
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst16", {20'd0, v16, idx16, gnt16}, 32'h0);
    check_eq("async_rst4",  {20'd0, v4,  idx4,  gnt4},  32'h0);
    model_reset();
    rst_n  = 1'b1;
    snap16 = 8'h00;
    snap4  = 8'h00;
  endtask

  // Invariants, plus proof that input changes after an edge never reach gnt.
  always @(negedge clk) begin
    if (inv_on && rst_n) begin
      check_eq("onehot16", 32'($onehot0(gnt16)), 32'd1);
      check_eq("onehot4",  32'($onehot0(gnt4)),  32'd1);
      check_eq("valid16",  32'(v16), 32'(|gnt16));
      check_eq("valid4",   32'(v4),  32'(|gnt4));
      check_eq("idxdec16", 32'(gnt16), 32'(v16 ? (8'h01 << idx16) : 8'h00));
      check_eq("idxdec4",  32'(gnt4),  32'(v4 ? (8'h01 << idx4) : 8'h00));
      check_eq("no_comb16", 32'(gnt16), 32'(snap16));
      check_eq("no_comb4",  32'(gnt4),  32'(snap4));
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    model_reset();
    #2;
    check_eq("reset16", {20'd0, v16, idx16, gnt16}, 32'h0);
    check_eq("reset4",  {20'd0, v4,  idx4,  gnt4},  32'h0);
    #20 rst_n = 1'b1;
    inv_on = 1'b1;

    // First grant after reset starts searching at index 0.
    step();
    check_eq("first_grant16", 32'(gnt16), 32'h01);
    check_eq("first_grant4",  32'(gnt4),  32'h01);

    // Single requester keeps the grant indefinitely.
    apply_reset();
    req = 8'h08;
    step();
    check_eq("single_gnt", 32'(gnt16), 32'h08);
    check_eq("single_idx", 32'(idx16), 32'd3);
    for (int k = 0; k < 40; k++) step();
    check_eq("single_hold16", 32'(gnt16), 32'h08);
    check_eq("single_hold4",  32'(gnt4),  32'h08);

    // Fair rotation with hold limit 4: each index owns exactly 4 cycles.
    apply_reset();
    req = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] e;
      step();
      e = 8'h01 << ((k / 4) % 8);
      check_eq("rotate4", 32'(gnt4), 32'(e));
    end

    // Zero-bubble handoff on release.
    apply_reset();
    req = 8'h05;
    step();
    check_eq("handoff_pre", 32'(gnt16), 32'h01);
    req = 8'h04;
    step();
    check_eq("handoff_gnt",   32'(gnt16), 32'h04);
    check_eq("handoff_valid", 32'(v16),   32'd1);

    // Wrap from index 6: 7 is next, then 0.
    apply_reset();
    req = 8'h40;
    step();
    req = 8'h00;
    step();
    check_eq("idle_idx_held", {29'd0, idx16}, 32'd6);
    check_eq("idle_valid",    32'(v16), 32'd0);
    req = 8'h81;
    step();
    check_eq("wrap_7", 32'(gnt16), 32'h80);
    req = 8'h01;
    step();
    check_eq("wrap_0", 32'(gnt16), 32'h01);

    // Disabled arbitration, then reset mid-grant.
    apply_reset();
    en  = 1'b0;
    req = 8'h10;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("en_off", 32'(gnt16), 32'h00);
    end
    en = 1'b1;
    step();
    check_eq("en_on", 32'(gnt16), 32'h10);
    step();
    apply_reset();
    req = 8'hFF;
    step();
    check_eq("post_rst_grant", 32'(gnt16), 32'h01);

    // Randomized traffic with sparse request flips, occasional en drops and resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) req = req ^ (8'($urandom) & 8'($urandom));
      en = ($urandom_range(0, 15) != 0);
      step();
      if ($urandom_range(0, 499) == 0) apply_reset();
    end

    inv_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
